alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared 8-bit ALU.
// Round-robin grant in IDLE, fixed-length operation in EXEC, and the
// response is held in RESP until the consumer takes it.
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned ALU_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [1:0] req_op0,
  input  logic [1:0] req_op1,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b1,
  output logic [1:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_r,
  input  logic [5:0] alu_flags,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_r,
  output logic [5:0] rsp_flags,
  input  logic       rsp_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b11;
  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] ALU_CNT = 4'(ALU_CYCLES);

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       gnt_q, gnt_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_r_q, rsp_r_d;
  logic [5:0] rsp_flags_q, rsp_flags_d;

  // Requester selection: pointer breaks ties, a lone requester always wins.
  logic       gnt_any;
  logic       gnt_sel;
  logic [1:0] sel_op;
  logic [7:0] sel_a;
  logic [7:0] sel_b;

  assign gnt_any = |req_valid;
  assign gnt_sel = (&req_valid) ? ptr_q : ~req_valid[0];
  assign sel_op  = gnt_sel ? req_op1 : req_op0;
  assign sel_a   = gnt_sel ? req_a1  : req_a0;
  assign sel_b   = gnt_sel ? req_b1  : req_b0;

  // Next-state and output decode; ALU bus and ready are zero unless driven.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = gnt_q;
    rsp_id_d    = rsp_id_q;
    rsp_r_d     = rsp_r_q;
    rsp_flags_d = rsp_flags_q;
    req_ready   = 2'b00;
    alu_op      = 2'b00;
    alu_a       = 8'h00;
    alu_b       = 8'h00;

    case (state_q)
      IDLE: begin
        // Ready is combinational, so it must be masked while reset is held.
        if (gnt_any && !reset) begin
          req_ready = gnt_sel ? 2'b10 : 2'b01;
          op_d      = sel_op;
          a_d       = sel_a;
          b_d       = sel_b;
          gnt_d     = gnt_sel;
          cnt_d     = (sel_op == OP_MUL) ? MUL_CNT : ALU_CNT;
          state_d   = EXEC;
        end
      end

      EXEC: begin
        alu_op = op_q;
        alu_a  = a_q;
        alu_b  = b_q;
        // Treat a count of 0 as final too, so an illegal 0 parameter cannot hang.
        if (cnt_q <= 4'd1) begin
          rsp_r_d     = alu_r;
          rsp_flags_d = alu_flags;
          rsp_id_d    = gnt_q;
          cnt_d       = 4'd0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        // Returning to IDLE takes this cycle; the next grant happens in IDLE.
        if (rsp_ready) begin
          ptr_d   = ~rsp_id_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= 4'd0;
      op_q        <= 2'b00;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      gnt_q       <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_r_q     <= 8'h00;
      rsp_flags_q <= 6'h00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      rsp_id_q    <= rsp_id_d;
      rsp_r_q     <= rsp_r_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (accept at t, respond at t+N+1).
module tb_alu_arbiter;

  localparam int MULC = 2;
  localparam int ALUC = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_op0, req_op1;
  logic [7:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_r;
  logic [5:0] alu_flags;
  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_r;
  logic [5:0] rsp_flags;
  logic       rsp_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.MUL_CYCLES(MULC), .ALU_CYCLES(ALUC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_r(alu_r), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_flags(rsp_flags),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // Behavioural ALU: returns {z, n, vn, vp, br, c, r}
  function automatic logic [13:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic vn, vp, br, c;
    vn = 1'b0; vp = 1'b0; br = 1'b0; c = 1'b0; r = 8'h00; s = 9'h0; p = 16'h0;
    case (op)
      2'b00: r = a & b;
      2'b01: begin
        s = {1'b0, a} - {1'b0, b}; r = s[7:0]; br = s[8];
        vn = a[7] & ~b[7] & ~r[7]; vp = ~a[7] & b[7] & r[7];
      end
      2'b10: begin
        s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
        vn = a[7] & b[7] & ~r[7]; vp = ~a[7] & ~b[7] & r[7];
      end
      default: begin
        p = a * b; r = p[7:0]; c = |p[15:8];
      end
    endcase
    return {(r == 8'h00), r[7], vn, vp, br, c, r};
  endfunction

  always_comb {alu_flags, alu_r} = alu_fn(alu_op, alu_a, alu_b);

  // ---------------- reference model (transaction level) ----------------
  logic       m_busy, m_ptr, m_id;
  int         m_age, m_n;
  logic [1:0] m_op;
  logic [7:0] m_a, m_b, m_r;
  logic [5:0] m_f;
  logic       e_gnt, e_gid, e_rsp_valid, e_exec;
  logic [1:0] e_ready;
  logic [17:0] e_alu;

  always_comb begin
    e_gnt       = !reset && !m_busy && (req_valid != 2'b00);
    e_gid       = (req_valid == 2'b11) ? m_ptr : req_valid[1];
    e_ready     = e_gnt ? (e_gid ? 2'b10 : 2'b01) : 2'b00;
    e_rsp_valid = m_busy && (m_age > m_n);
    e_exec      = m_busy && (m_age >= 1) && (m_age <= m_n);
    e_alu       = e_exec ? {m_op, m_a, m_b} : 18'h0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_ptr <= 1'b0; m_age <= 0;
    end else if (e_gnt) begin
      m_busy <= 1'b1;
      m_age  <= 1;
      m_id   <= e_gid;
      m_op   <= e_gid ? req_op1 : req_op0;
      m_a    <= e_gid ? req_a1 : req_a0;
      m_b    <= e_gid ? req_b1 : req_b0;
      m_n    <= ((e_gid ? req_op1 : req_op0) == 2'b11) ? MULC : ALUC;
      {m_f, m_r} <= e_gid ? alu_fn(req_op1, req_a1, req_b1) : alu_fn(req_op0, req_a0, req_b0);
    end else if (m_busy) begin
      if (e_rsp_valid && rsp_ready) begin
        m_busy <= 1'b0;
        m_ptr  <= ~m_id;
      end else if (m_age <= m_n) begin
        m_age <= m_age + 1;
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_req(input int k);
    if (k == 0) begin
      req_op0 = 2'($urandom_range(0, 3)); req_a0 = 8'($urandom); req_b0 = 8'($urandom);
    end else begin
      req_op1 = 2'($urandom_range(0, 3)); req_a1 = 8'($urandom); req_b1 = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    req_valid = 2'b00; rsp_ready = 1'b1; n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk); n++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy=%b still set after %0d cycles, required 0", busy, n);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req_op0 = 2'b00; req_op1 = 2'b00; req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b required 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if ({rsp_id, rsp_r, rsp_flags} !== 15'h0) begin errors++; $display("FAIL reset_rsp_data: got %h required 0", {rsp_id, rsp_r, rsp_flags}); end
    checks++; if ({alu_op, alu_a, alu_b} !== 18'h0) begin errors++; $display("FAIL reset_alu_bus: got %h required 0", {alu_op, alu_a, alu_b}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 2'b00;
    tick();
  endtask

  task automatic test_add_directed();
    req_valid = 2'b01; req_op0 = 2'b10; req_a0 = 8'h05; req_b0 = 8'hFD; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_ready: got %b required 01", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_idle_busy: got %b required 0", busy); end
    tick(); req_valid = 2'b00; req_a0 = 8'h77;
    @(negedge clk);
    checks++; if ({alu_op, alu_a, alu_b} !== {2'b10, 8'h05, 8'hFD}) begin errors++; $display("FAIL add_alu_bus: got %h required %h", {alu_op, alu_a, alu_b}, {2'b10, 8'h05, 8'hFD}); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_exec_flags: got valid=%b busy=%b required 0/1", rsp_valid, busy); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency: rsp_valid got %b required 1 at t+2", rsp_valid); end
    checks++; if ({rsp_id, rsp_r, rsp_flags} !== {1'b0, 8'h02, 6'b000001}) begin errors++; $display("FAIL add_rsp: got id=%b r=%h f=%b required 0/02/000001", rsp_id, rsp_r, rsp_flags); end
    checks++; if ({alu_op, alu_a, alu_b} !== 18'h0) begin errors++; $display("FAIL add_alu_idle: got %h required 0", {alu_op, alu_a, alu_b}); end
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL add_return: got busy=%b valid=%b required 0/0", busy, rsp_valid); end
    tick();
  endtask

  task automatic test_mul_directed();
    req_valid = 2'b10; req_op1 = 2'b11; req_a1 = 8'h03; req_b1 = 8'hFE; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mul_ready: got %b required 10", req_ready); end
    for (int c = 1; c <= MULC; c++) begin
      tick(); req_valid = 2'b00; req_b1 = 8'($urandom);
      @(negedge clk);
      checks++; if ({alu_op, alu_a, alu_b} !== {2'b11, 8'h03, 8'hFE}) begin errors++; $display("FAIL mul_alu_bus_c%0d: got %h required %h", c, {alu_op, alu_a, alu_b}, {2'b11, 8'h03, 8'hFE}); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mul_early_valid_c%0d: got %b required 0", c, rsp_valid); end
    end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_r !== 8'hFA) begin errors++; $display("FAIL mul_rsp: got valid=%b id=%b r=%h required 1/1/FA", rsp_valid, rsp_id, rsp_r); end
    tick();
  endtask

  task automatic test_round_robin();
    int ngr, n;
    logic gid;
    rand_req(0); rand_req(1); req_valid = 2'b11; rsp_ready = 1'b1;
    ngr = 0; n = 0;
    while (ngr < 4 && n < 60) begin
      @(negedge clk);
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rr_ready: got %b required %b", req_ready, e_ready); end
      checks++; if (req_ready === 2'b11) begin errors++; $display("FAIL rr_onehot: got %b required at most one bit", req_ready); end
      if (req_ready == 2'b01 || req_ready == 2'b10) begin
        gid = req_ready[1];
        checks++; if (gid !== 1'(ngr % 2)) begin errors++; $display("FAIL rr_order: grant %0d got requester %0d required %0d", ngr, gid, ngr % 2); end
        ngr++;
      end
      @(posedge clk); #1;
      if (req_ready[0]) rand_req(0);
      if (req_ready[1]) rand_req(1);
      n++;
    end
    checks++; if (ngr < 4) begin errors++; $display("FAIL rr_timeout: got %0d grants required 4", ngr); end
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [13:0] exp;
    int n;
    req_valid = 2'b01; rand_req(0); rsp_ready = 1'b0;
    exp = alu_fn(req_op0, req_a0, req_b0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_ready: got %b required 01", req_ready); end
    tick(); req_valid = 2'b00; n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: rsp_valid got %b required 1", rsp_valid); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      req_valid = 2'b11; rand_req(0); rand_req(1);
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_id, rsp_flags, rsp_r} !== {2'b10, exp}) begin errors++; $display("FAIL bp_hold_c%0d: got %h required %h", c, {rsp_valid, rsp_id, rsp_flags, rsp_r}, {2'b10, exp}); end
      checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL bp_stall_c%0d: got ready=%b busy=%b required 00/1", c, req_ready, busy); end
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_no_same_cycle_grant: got %b required 00", req_ready); end
    tick();
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b required 10", req_ready); end
    tick();
    wait_idle();
  endtask

  task automatic test_random();
    logic [1:0] rdy;
    rsp_ready = 1'b1; req_valid = 2'b00;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b required %b", c, req_ready, e_ready); end
      checks++; if (rsp_valid !== e_rsp_valid || busy !== m_busy) begin errors++; $display("FAIL rnd_status c%0d: got valid=%b busy=%b required %b/%b", c, rsp_valid, busy, e_rsp_valid, m_busy); end
      checks++; if ({alu_op, alu_a, alu_b} !== e_alu) begin errors++; $display("FAIL rnd_alu_bus c%0d: got %h required %h", c, {alu_op, alu_a, alu_b}, e_alu); end
      if (e_rsp_valid) begin
        checks++; if ({rsp_id, rsp_r, rsp_flags} !== {m_id, m_r, m_f}) begin errors++; $display("FAIL rnd_rsp c%0d: got id=%b r=%h f=%b required %b/%h/%b", c, rsp_id, rsp_r, rsp_flags, m_id, m_r, m_f); end
      end
      rdy = req_ready;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (rdy[k]) begin
          rand_req(k);
          req_valid[k] = ($urandom_range(0, 1) == 1);
        end else if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          rand_req(k);
          req_valid[k] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_exec();
    req_valid = 2'b10; req_op1 = 2'b11; req_a1 = 8'h9C; req_b1 = 8'h4B; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rst_mid_grant: got %b required 10", req_ready); end
    tick(); req_valid = 2'b00;
    tick();
    #2; reset = 1'b1; req_valid = 2'b11;
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_id, rsp_r, rsp_flags, alu_op, alu_a, alu_b, busy} !== 37'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h required 0", {req_ready, rsp_valid, rsp_id, rsp_r, rsp_flags, alu_op, alu_a, alu_b, busy});
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rsp c%0d: got valid=%b busy=%b required 0/0", c, rsp_valid, busy); end
      @(posedge clk); #1;
    end
    req_valid = 2'b11; rand_req(0); rand_req(1);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_grant: got %b required 01", req_ready); end
    tick();
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_add_directed();
    test_mul_directed();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
